irq_service_sequencer: RTL and testbench

- APB master that services the interrupt controller without CPU polling.
- After reset it writes the enable/mask register once.
- On each interrupt assertion it reads the pending register, picks the highest-priority source, presents its vector to a downstream consumer with a valid/ack handshake, then clears the source with a write-1-to-clear access.
- Sits between the interrupt controller's APB slave port and the core/event consumer.

---
 rtl/irq_service_sequencer_pkg.sv | 44 ++++
 rtl/irq_service_sequencer_if.sv | 24 ++
 rtl/irq_service_sequencer_priority_encoder.sv | 24 ++
 rtl/irq_service_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_irq_service_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_service_sequencer_pkg.sv
// Shared definitions for the interrupt service sequencer: FSM states, APB phases
// and the interrupt controller register map.
package irq_service_sequencer_pkg;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

   // Register map shared with the interrupt controller's APB slave port.
   localparam logic [APB_AW-1:0] DEF_ENABLE_ADDR = 32'h0000_0000;
   localparam logic [APB_AW-1:0] DEF_STATUS_ADDR = 32'h0000_0004;
   localparam logic [APB_AW-1:0] DEF_CLEAR_ADDR  = 32'h0000_0008;
   localparam logic [APB_DW-1:0] DEF_INIT_MASK   = 32'h0000_000F;

   typedef enum logic [3:0] {
      ST_CFG_SETUP,
      ST_CFG_ACCESS,
      ST_IDLE,
      ST_RD_SETUP,
      ST_RD_ACCESS,
      ST_DECODE,
      ST_DELIVER,
      ST_WR_SETUP,
      ST_WR_ACCESS
   } seq_state_e;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_phase_e;

   function automatic apb_phase_e phase_of(input seq_state_e s);
      case (s)
         ST_CFG_SETUP, ST_RD_SETUP, ST_WR_SETUP:    return APB_SETUP;
         ST_CFG_ACCESS, ST_RD_ACCESS, ST_WR_ACCESS: return APB_ACCESS;
         default:                                   return APB_IDLE;
      endcase
   endfunction

   function automatic logic [APB_DW-1:0] onehot32(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/irq_service_sequencer_if.sv
// APB bus between the sequencer (master) and the interrupt controller (slave).
interface irq_service_sequencer_if;
   import irq_service_sequencer_pkg::*;

   logic [APB_AW-1:0] paddr_o;
   logic              psel_o;
   logic              penable_o;
   logic              pwrite_o;
   logic [APB_DW-1:0] pwdata_o;
   logic [APB_DW-1:0] prdata_i;
   logic              pready_i;
   logic              pslverr_i;

   modport master (
      output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
      input  prdata_i, pready_i, pslverr_i
   );

   modport slave (
      input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o,
      output prdata_i, pready_i, pslverr_i
   );

endinterface

// File: rtl/irq_service_sequencer_priority_encoder.sv
// Fixed-priority encoder: the lowest set pending bit wins (bit 0 is highest priority).
module irq_priority_encoder #(
   parameter int N_IRQ = 4
) (
   input  logic [N_IRQ-1:0]         pending_i,
   output logic [$clog2(N_IRQ)-1:0] idx_o,
   output logic                     any_o
);

   localparam int VEC_W = $clog2(N_IRQ);

   // Scan from the top down so the last match, the lowest index, is what remains.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (pending_i[i]) begin
            idx_o = VEC_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_service_sequencer.sv
// APB master that configures the interrupt controller once, then reads, delivers
// and clears the highest-priority pending interrupt on every interrupt assertion.
module irq_service_sequencer
   import irq_service_sequencer_pkg::*;
#(
   parameter int                N_IRQ       = 4,
   parameter logic [APB_AW-1:0] ENABLE_ADDR = DEF_ENABLE_ADDR,
   parameter logic [APB_AW-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter logic [APB_AW-1:0] CLEAR_ADDR  = DEF_CLEAR_ADDR,
   parameter logic [APB_DW-1:0] INIT_MASK   = DEF_INIT_MASK,
   parameter int                TIMEOUT     = 16
) (
   input  logic                     pclk_i,
   input  logic                     rst_n_i,
   input  logic                     interrupt_i,
   irq_service_sequencer_if.master  apb,
   output logic                     irq_valid_o,
   output logic [$clog2(N_IRQ)-1:0] irq_vec_o,
   input  logic                     irq_ack_i,
   output logic                     busy_o,
   output logic                     err_o,
   output logic [7:0]               spurious_cnt_o
);

   localparam int VEC_W = $clog2(N_IRQ);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   seq_state_e        state_q, state_d;
   logic [APB_AW-1:0] paddr_q, paddr_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [APB_DW-1:0] pwdata_q, pwdata_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [N_IRQ-1:0]  pending_q, pending_d;
   logic              valid_q, valid_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [7:0]        spur_q, spur_d;

   logic [VEC_W-1:0]  enc_idx;
   logic              enc_any;
   logic              access_timeout;

   irq_priority_encoder #(.N_IRQ(N_IRQ)) u_prio (
      .pending_i (pending_q),
      .idx_o     (enc_idx),
      .any_o     (enc_any)
   );

   // All outputs are registered from the next state, so the bus shows the phase of
   // the state being entered. Right after reset CFG_SETUP is entered with psel low,
   // so it holds one extra cycle to present a proper setup phase.
   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      tmo_d     = tmo_q;
      pending_d = pending_q;
      valid_d   = valid_q;
      vec_d     = vec_q;
      err_d     = err_q;
      spur_d    = spur_q;

      access_timeout = !apb.pready_i && (tmo_q == TMO_W'(TIMEOUT - 1));

      case (state_q)
         ST_CFG_SETUP: if (psel_q) state_d = ST_CFG_ACCESS;
         ST_CFG_ACCESS, ST_WR_ACCESS: begin
            if (apb.pready_i) begin
               err_d   = err_q | apb.pslverr_i;
               state_d = ST_IDLE;
            end else if (access_timeout) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_IDLE:     if (interrupt_i) state_d = ST_RD_SETUP;
         ST_RD_SETUP: state_d = ST_RD_ACCESS;
         ST_RD_ACCESS: begin
            if (apb.pready_i) begin
               if (apb.pslverr_i) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  pending_d = apb.prdata_i[N_IRQ-1:0];
                  state_d   = ST_DECODE;
               end
            end else if (access_timeout) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_DECODE: begin
            if (enc_any) begin
               vec_d   = enc_idx;
               valid_d = 1'b1;
               state_d = ST_DELIVER;
            end else begin
               if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         ST_DELIVER: begin
            if (irq_ack_i) begin
               valid_d = 1'b0;
               state_d = ST_WR_SETUP;
            end
         end
         ST_WR_SETUP: state_d = ST_WR_ACCESS;
         default:     state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_CFG_SETUP: begin
            paddr_d  = ENABLE_ADDR;
            pwrite_d = 1'b1;
            pwdata_d = INIT_MASK;
            tmo_d    = '0;
         end
         ST_RD_SETUP: begin
            paddr_d  = STATUS_ADDR;
            pwrite_d = 1'b0;
            tmo_d    = '0;
         end
         ST_WR_SETUP: begin
            paddr_d  = CLEAR_ADDR;
            pwrite_d = 1'b1;
            pwdata_d = onehot32(5'(vec_q));
            tmo_d    = '0;
         end
         default: ;
      endcase

      psel_d    = (phase_of(state_d) != APB_IDLE);
      penable_d = (phase_of(state_d) == APB_ACCESS);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge pclk_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_CFG_SETUP;
         paddr_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         tmo_q     <= '0;
         pending_q <= '0;
         valid_q   <= 1'b0;
         vec_q     <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         spur_q    <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         tmo_q     <= tmo_d;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         vec_q     <= vec_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         spur_q    <= spur_d;
      end
   end

   assign apb.paddr_o    = paddr_q;
   assign apb.psel_o     = psel_q;
   assign apb.penable_o  = penable_q;
   assign apb.pwrite_o   = pwrite_q;
   assign apb.pwdata_o   = pwdata_q;
   assign irq_valid_o    = valid_q;
   assign irq_vec_o      = vec_q;
   assign busy_o         = busy_q;
   assign err_o          = err_q;
   assign spurious_cnt_o = spur_q;

endmodule

// File: tb/tb_irq_service_sequencer.sv
// Directed bench: an APB slave model and a vector consumer check the sequencer
// against queues of expected bus transfers and vectors.
module tb_irq_service_sequencer;
   import irq_service_sequencer_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
   } apb_txn_t;

   logic       pclk_i = 1'b0;
   logic       rst_n_i;
   logic       interrupt_i;
   logic       irq_valid_o;
   logic [1:0] irq_vec_o;
   logic       irq_ack_i;
   logic       busy_o;
   logic       err_o;
   logic [7:0] spurious_cnt_o;

   irq_service_sequencer_if apb ();

   irq_service_sequencer dut (
      .pclk_i         (pclk_i),
      .rst_n_i        (rst_n_i),
      .interrupt_i    (interrupt_i),
      .apb            (apb.master),
      .irq_valid_o    (irq_valid_o),
      .irq_vec_o      (irq_vec_o),
      .irq_ack_i      (irq_ack_i),
      .busy_o         (busy_o),
      .err_o          (err_o),
      .spurious_cnt_o (spurious_cnt_o)
   );

   always #5 pclk_i = ~pclk_i;

   int test_count = 0;
   int fail_count = 0;

   apb_txn_t    exp_apb[$];
   logic [31:0] status_q[$];
   logic [1:0]  exp_vec[$];

   int   cyc = 0;
   int   psel_hi = 0;
   int   access_cnt = 0;
   int   last_done_cyc = 0;
   bit   last_done_write = 1'b0;
   bit   check_gap = 1'b0;
   bit   hang = 1'b0;
   bit   slverr_on_write = 1'b0;
   int   vld_cnt = 0;
   int   ack_delay = 3;
   int   vec_done = 0;
   logic [1:0] cur_exp = '0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_count++;
      assert (obs === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic irq_level);
      interrupt_i = irq_level;
   endtask

   task automatic pushXfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
      apb_txn_t t;
      t.addr  = addr;
      t.write = write;
      t.wdata = wdata;
      exp_apb.push_back(t);
   endtask

   task automatic checkQueues(input string tag);
      checkOutput({tag, "_apb_left"}, 32'(exp_apb.size()), 32'd0);
      checkOutput({tag, "_vec_left"}, 32'(exp_vec.size()), 32'd0);
   endtask

   task automatic waitIdle(input int max_cycles);
      for (int i = 0; i < max_cycles && busy_o; i++) @(negedge pclk_i);
      checkOutput("wait_idle", 32'(busy_o), 32'd0);
   endtask

   task automatic waitVec(input int target);
      for (int i = 0; i < 300 && vec_done < target; i++) @(negedge pclk_i);
      checkOutput("wait_vec", 32'(vec_done), 32'(target));
   endtask

   // Reset one cycle, verify every output is cleared, then expect the CFG write.
   task automatic resetDut();
      int snap;
      rst_n_i   = 1'b0;
      irq_ack_i = 1'b0;
      @(negedge pclk_i);
      checkOutput("rst_psel",    32'(apb.psel_o),    32'd0);
      checkOutput("rst_penable", 32'(apb.penable_o), 32'd0);
      checkOutput("rst_pwrite",  32'(apb.pwrite_o),  32'd0);
      checkOutput("rst_paddr",   apb.paddr_o,        32'd0);
      checkOutput("rst_pwdata",  apb.pwdata_o,       32'd0);
      checkOutput("rst_valid",   32'(irq_valid_o),   32'd0);
      checkOutput("rst_vec",     32'(irq_vec_o),     32'd0);
      checkOutput("rst_busy",    32'(busy_o),        32'd0);
      checkOutput("rst_err",     32'(err_o),         32'd0);
      checkOutput("rst_spur",    32'(spurious_cnt_o), 32'd0);
      repeat (2) @(negedge pclk_i);
      pushXfer(DEF_ENABLE_ADDR, 1'b1, DEF_INIT_MASK);
      snap    = psel_hi;
      rst_n_i = 1'b1;
      repeat (2) @(negedge pclk_i);
      waitIdle(50);
      checkOutput("cfg_psel_cycles", 32'(psel_hi - snap), 32'd2);
      checkQueues("cfg");
   endtask

   // APB slave model and transfer scoreboard.
   always @(negedge pclk_i) begin
      apb_txn_t e;
      cyc++;
      apb.pready_i  = 1'b0;
      apb.pslverr_i = 1'b0;
      if (apb.psel_o) psel_hi++;
      if (apb.psel_o && !apb.penable_o && check_gap && last_done_write) begin
         checkOutput("loop_gap", 32'(cyc - last_done_cyc), 32'd2);
         check_gap = 1'b0;
      end
      if (apb.psel_o && apb.penable_o) begin
         access_cnt++;
         if (!hang) begin
            apb.pready_i = 1'b1;
            if (!apb.pwrite_o) apb.prdata_i = (status_q.size() > 0) ? status_q.pop_front() : 32'd0;
            if (apb.pwrite_o && slverr_on_write) begin
               apb.pslverr_i   = 1'b1;
               slverr_on_write = 1'b0;
            end
            if (exp_apb.size() == 0) begin
               checkOutput("unexpected_xfer", apb.paddr_o, 32'hFFFF_FFFF);
            end else begin
               e = exp_apb.pop_front();
               checkOutput("xfer_addr",  apb.paddr_o,        e.addr);
               checkOutput("xfer_write", 32'(apb.pwrite_o),  32'(e.write));
               if (e.write) checkOutput("xfer_wdata", apb.pwdata_o, e.wdata);
            end
            last_done_cyc   = cyc;
            last_done_write = apb.pwrite_o;
         end
      end
   end

   // Vector consumer: checks each delivered vector and its stability until ack.
   always @(negedge pclk_i) begin
      if (irq_ack_i) begin
         irq_ack_i = 1'b0;
         checkOutput("valid_drop", 32'(irq_valid_o), 32'd0);
      end else if (irq_valid_o) begin
         if (vld_cnt == 0) begin
            if (exp_vec.size() == 0) begin
               checkOutput("unexpected_valid", 32'(irq_valid_o), 32'd0);
               cur_exp = irq_vec_o;
            end else begin
               cur_exp = exp_vec.pop_front();
               checkOutput("vec", 32'(irq_vec_o), 32'(cur_exp));
            end
         end else begin
            checkOutput("vec_hold", 32'(irq_vec_o), 32'(cur_exp));
         end
         if (vld_cnt == ack_delay) begin
            irq_ack_i = 1'b1;
            vec_done++;
            vld_cnt = 0;
         end else begin
            vld_cnt++;
         end
      end else begin
         vld_cnt = 0;
      end
   end

   initial begin
      repeat (20000) @(posedge pclk_i);
      $display("[TB] FAIL watchdog: simulation did not finish within 20000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      rst_n_i       = 1'b0;
      interrupt_i   = 1'b0;
      irq_ack_i     = 1'b0;
      apb.prdata_i  = '0;
      apb.pready_i  = 1'b0;
      apb.pslverr_i = 1'b0;

      resetDut();
      checkOutput("cfg_err", 32'(err_o), 32'd0);

      // Two back-to-back services: status 0110 then 0001.
      status_q.push_back(32'h6);
      status_q.push_back(32'h1);
      pushXfer(DEF_STATUS_ADDR, 1'b0, 32'h0);
      pushXfer(DEF_CLEAR_ADDR,  1'b1, 32'h2);
      pushXfer(DEF_STATUS_ADDR, 1'b0, 32'h0);
      pushXfer(DEF_CLEAR_ADDR,  1'b1, 32'h1);
      exp_vec.push_back(2'd1);
      exp_vec.push_back(2'd0);
      ack_delay = 3;
      check_gap = 1'b1;
      base = vec_done;
      applyStimulus(1'b1);
      waitVec(base + 2);
      applyStimulus(1'b0);
      waitIdle(50);
      checkOutput("gap_seen", 32'(check_gap), 32'd0);
      checkQueues("svc");

      // Three spurious reads.
      repeat (3) begin
         status_q.push_back(32'h0);
         pushXfer(DEF_STATUS_ADDR, 1'b0, 32'h0);
      end
      applyStimulus(1'b1);
      for (int i = 0; i < 100 && spurious_cnt_o != 8'd3; i++) @(negedge pclk_i);
      applyStimulus(1'b0);
      checkOutput("spur_cnt", 32'(spurious_cnt_o), 32'd3);
      waitIdle(20);
      checkOutput("spur_valid", 32'(irq_valid_o), 32'd0);
      checkQueues("spur");

      // Status read never gets pready.
      checkOutput("pre_tmo_err", 32'(err_o), 32'd0);
      hang = 1'b1;
      base = access_cnt;
      applyStimulus(1'b1);
      for (int i = 0; i < 100 && !err_o; i++) @(negedge pclk_i);
      applyStimulus(1'b0);
      checkOutput("tmo_err",     32'(err_o),         32'd1);
      checkOutput("tmo_psel",    32'(apb.psel_o),    32'd0);
      checkOutput("tmo_penable", 32'(apb.penable_o), 32'd0);
      checkOutput("tmo_busy",    32'(busy_o),        32'd0);
      checkOutput("tmo_cycles",  32'(access_cnt - base), 32'd16);
      hang = 1'b0;
      repeat (3) @(negedge pclk_i);
      checkOutput("tmo_quiet", 32'(apb.psel_o), 32'd0);

      // Slave error on the clear write, then a normal service with err_o sticky.
      resetDut();
      status_q.push_back(32'h8);
      pushXfer(DEF_STATUS_ADDR, 1'b0, 32'h0);
      pushXfer(DEF_CLEAR_ADDR,  1'b1, 32'h8);
      exp_vec.push_back(2'd3);
      slverr_on_write = 1'b1;
      base = vec_done;
      applyStimulus(1'b1);
      waitVec(base + 1);
      applyStimulus(1'b0);
      waitIdle(20);
      checkOutput("slverr_err", 32'(err_o), 32'd1);
      checkQueues("slverr");
      status_q.push_back(32'h4);
      pushXfer(DEF_STATUS_ADDR, 1'b0, 32'h0);
      pushXfer(DEF_CLEAR_ADDR,  1'b1, 32'h4);
      exp_vec.push_back(2'd2);
      base = vec_done;
      applyStimulus(1'b1);
      waitVec(base + 1);
      applyStimulus(1'b0);
      waitIdle(20);
      checkOutput("sticky_err", 32'(err_o), 32'd1);
      checkQueues("after_err");

      // Reset while a vector is waiting for its ack.
      status_q.push_back(32'h1);
      pushXfer(DEF_STATUS_ADDR, 1'b0, 32'h0);
      exp_vec.push_back(2'd0);
      ack_delay = 1000;
      applyStimulus(1'b1);
      for (int i = 0; i < 50 && !irq_valid_o; i++) @(negedge pclk_i);
      checkOutput("deliver_valid", 32'(irq_valid_o), 32'd1);
      applyStimulus(1'b0);
      resetDut();
      ack_delay = 3;
      repeat (3) @(negedge pclk_i);
      checkOutput("post_rst_valid", 32'(irq_valid_o), 32'd0);
      checkQueues("final");

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
